// File: rtl/sw_stripe_scheduler.sv
// sw_stripe_scheduler: stripe sequencer, boundary store/replay and max reduction for a systolic SW PE array
// Ports: clk/reset; valid/data_ref/data_query serial load; pe_query_load/pe_query/pe_col_mask stripe setup;
//        pe_ref_valid/pe_ref/pe_bnd_h/pe_bnd_i row issue; pe_last_* last-PE returns; pe_best_* best-cell reports;
//        busy/finish status; max/pos_ref/pos_query best score and its position.
module sw_stripe_scheduler #(
    parameter int LEN_REF         = 64,
    parameter int LEN_QUERY       = 48,
    parameter int PE_NUM          = 16,
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6,
    parameter int WIDTH_HI        = 7,
    parameter int NEG_INIT        = -30
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid,
    input  logic [1:0]                        data_ref,
    input  logic [1:0]                        data_query,
    output logic                              pe_query_load,
    output logic [2*PE_NUM-1:0]               pe_query,
    output logic [PE_NUM-1:0]                 pe_col_mask,
    output logic                              pe_ref_valid,
    output logic [1:0]                        pe_ref,
    output logic signed [WIDTH_HI-1:0]        pe_bnd_h,
    output logic signed [WIDTH_HI-1:0]        pe_bnd_i,
    input  logic                              pe_last_valid,
    input  logic signed [WIDTH_HI-1:0]        pe_last_h,
    input  logic signed [WIDTH_HI-1:0]        pe_last_i,
    input  logic                              pe_best_valid,
    input  logic [WIDTH_SCORE-1:0]            pe_best_score,
    input  logic [WIDTH_POS_REF-1:0]          pe_best_row,
    input  logic [WIDTH_POS_QUERY-1:0]        pe_best_col,
    output logic                              busy,
    output logic                              finish,
    output logic [WIDTH_SCORE-1:0]            max,
    output logic [WIDTH_POS_REF-1:0]          pos_ref,
    output logic [WIDTH_POS_QUERY-1:0]        pos_query
);
    localparam int NS = (LEN_QUERY + PE_NUM - 1) / PE_NUM;
    localparam int QN = NS * PE_NUM;
    localparam int ML = LEN_REF > LEN_QUERY ? LEN_REF : LEN_QUERY;
    localparam int RW = $clog2(LEN_REF);
    localparam int QW = $clog2(QN);
    localparam int NW = $clog2(ML + 1);
    localparam int WW = $clog2(LEN_REF + 2);
    localparam int SW = $clog2(NS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, ISSUE, DRAIN, DONE} state_t;

    state_t                     state;
    logic [1:0]                 r_mem [LEN_REF];
    // query buffer is padded to whole stripes; the tail is cleared at load start and never written
    logic [1:0]                 q_mem [QN];
    logic signed [WIDTH_HI-1:0] bnd_h [LEN_REF];
    logic signed [WIDTH_HI-1:0] bnd_i [LEN_REF];
    logic [NW-1:0]              n;
    logic [RW-1:0]              c;
    logic [RW-1:0]              rd;
    logic [WW-1:0]              wp;
    logic [SW-1:0]              s;
    logic [SW-1:0]              s_nxt;
    logic [2*PE_NUM-1:0]        q_nxt;
    logic [PE_NUM-1:0]          m_nxt;
    logic                       act;

    always_comb begin
        s_nxt = (state == LOAD) ? '0 : s + 1'b1;
        rd    = (state == SETUP) ? '0 : c + 1'b1;
        act   = state == ISSUE || state == DRAIN;
        q_nxt = '0;
        m_nxt = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            q_nxt[2*k +: 2] = q_mem[QW'(int'(s_nxt) * PE_NUM + k)];
            m_nxt[k]        = int'(s_nxt) * PE_NUM + k < LEN_QUERY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            finish        <= 1'b0;
            max           <= '0;
            pos_ref       <= '0;
            pos_query     <= '0;
            pe_query_load <= 1'b0;
            pe_query      <= '0;
            pe_col_mask   <= '0;
            pe_ref_valid  <= 1'b0;
            pe_ref        <= '0;
            pe_bnd_h      <= '0;
            pe_bnd_i      <= '0;
            n             <= '0;
            c             <= '0;
            wp            <= '0;
            s             <= '0;
        end else begin
            // rows of stripe s+1 are read only after every row of stripe s was written, so one buffer is enough
            if (act && pe_last_valid && wp <= WW'(LEN_REF)) begin
                bnd_h[RW'(wp - 1'b1)] <= pe_last_h;
                bnd_i[RW'(wp - 1'b1)] <= pe_last_i;
                wp                    <= wp + 1'b1;
            end
            // strict compare keeps the earliest report on ties
            if (act && pe_best_valid && pe_best_score > max) begin
                max       <= pe_best_score;
                pos_ref   <= pe_best_row;
                pos_query <= WIDTH_POS_QUERY'(int'(s) * PE_NUM) + pe_best_col;
            end
            case (state)
                IDLE: if (valid) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                    for (int i = 0; i < LEN_REF; i++) r_mem[i] <= '0;
                    for (int i = 0; i < QN; i++) q_mem[i] <= '0;
                    r_mem[0]  <= data_ref;
                    q_mem[0]  <= data_query;
                    n         <= NW'(1);
                    max       <= '0;
                    pos_ref   <= '0;
                    pos_query <= '0;
                end
                LOAD: if (valid) begin
                    if (n < NW'(LEN_REF)) r_mem[RW'(n)] <= data_ref;
                    if (n < NW'(LEN_QUERY)) q_mem[QW'(n)] <= data_query;
                    if (n < NW'(ML)) n <= n + 1'b1;
                end else begin
                    state         <= SETUP;
                    s             <= '0;
                    pe_query_load <= 1'b1;
                    pe_query      <= q_nxt;
                    pe_col_mask   <= m_nxt;
                end
                SETUP, ISSUE: begin
                    pe_query_load <= 1'b0;
                    if (state == SETUP) wp <= WW'(1);
                    if (state == ISSUE && c == RW'(LEN_REF - 1)) begin
                        state        <= DRAIN;
                        pe_ref_valid <= 1'b0;
                        pe_ref       <= '0;
                        pe_bnd_h     <= '0;
                        pe_bnd_i     <= '0;
                    end else begin
                        state        <= ISSUE;
                        c            <= rd;
                        pe_ref_valid <= 1'b1;
                        pe_ref       <= r_mem[rd];
                        pe_bnd_h     <= s == '0 ? '0 : bnd_h[rd];
                        pe_bnd_i     <= s == '0 ? WIDTH_HI'(NEG_INIT) : bnd_i[rd];
                    end
                end
                DRAIN: if (wp == WW'(LEN_REF + 1)) begin
                    if (int'(s) + 1 < NS) begin
                        state         <= SETUP;
                        s             <= s_nxt;
                        pe_query_load <= 1'b1;
                        pe_query      <= q_nxt;
                        pe_col_mask   <= m_nxt;
                    end else begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    finish <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sw_stripe_scheduler.sv
// tb_sw_stripe_scheduler: directed self-checking bench for sw_stripe_scheduler with a small PE array model
module tb_sw_stripe_scheduler;
    logic              clk = 0, reset = 1, valid = 0;
    logic [1:0]        data_ref = 0, data_query = 0;
    logic              pe_last_valid = 0;
    logic signed [6:0] pe_last_h = 0, pe_last_i = 0;
    logic              pe_best_valid = 0;
    logic [7:0]        pe_best_score = 0;
    logic [6:0]        pe_best_row = 0;
    logic [5:0]        pe_best_col = 0;

    logic              pe_query_load, pe_ref_valid, busy, finish;
    logic [31:0]       pe_query;
    logic [15:0]       pe_col_mask;
    logic [1:0]        pe_ref;
    logic signed [6:0] pe_bnd_h, pe_bnd_i;
    logic [7:0]        max;
    logic [6:0]        pos_ref;
    logic [5:0]        pos_query;

    logic              pe_query_load2, pe_ref_valid2, busy2, finish2;
    logic [31:0]       pe_query2;
    logic [15:0]       pe_col_mask2;
    logic [1:0]        pe_ref2;
    logic signed [6:0] pe_bnd_h2, pe_bnd_i2;
    logic [7:0]        max2;
    logic [6:0]        pos_ref2;
    logic [5:0]        pos_query2;

    int n_pass = 0, n_chk = 0, n_fail = 0;
    int cyc = 0, st = -1, row = 0;
    int due [1:64];
    bit late = 0, third = 0;

    always #5 clk = ~clk;

    sw_stripe_scheduler dut (
        .clk(clk), .reset(reset), .valid(valid), .data_ref(data_ref), .data_query(data_query),
        .pe_query_load(pe_query_load), .pe_query(pe_query), .pe_col_mask(pe_col_mask),
        .pe_ref_valid(pe_ref_valid), .pe_ref(pe_ref), .pe_bnd_h(pe_bnd_h), .pe_bnd_i(pe_bnd_i),
        .pe_last_valid(pe_last_valid), .pe_last_h(pe_last_h), .pe_last_i(pe_last_i),
        .pe_best_valid(pe_best_valid), .pe_best_score(pe_best_score), .pe_best_row(pe_best_row),
        .pe_best_col(pe_best_col), .busy(busy), .finish(finish), .max(max), .pos_ref(pos_ref),
        .pos_query(pos_query)
    );

    sw_stripe_scheduler #(.LEN_QUERY(40)) dut_lq40 (
        .clk(clk), .reset(reset), .valid(valid), .data_ref(data_ref), .data_query(data_query),
        .pe_query_load(pe_query_load2), .pe_query(pe_query2), .pe_col_mask(pe_col_mask2),
        .pe_ref_valid(pe_ref_valid2), .pe_ref(pe_ref2), .pe_bnd_h(pe_bnd_h2), .pe_bnd_i(pe_bnd_i2),
        .pe_last_valid(pe_last_valid), .pe_last_h(pe_last_h), .pe_last_i(pe_last_i),
        .pe_best_valid(pe_best_valid), .pe_best_score(pe_best_score), .pe_best_row(pe_best_row),
        .pe_best_col(pe_best_col), .busy(busy2), .finish(finish2), .max(max2), .pos_ref(pos_ref2),
        .pos_query(pos_query2)
    );

    initial for (int r = 1; r <= 64; r++) due[r] = -1;

    // PE model: row r returns h=r, i=-r two cycles after issue (row 64 another 20 when late)
    always @(negedge clk) begin
        cyc++;
        pe_last_valid = 0;
        pe_best_valid = 0;
        if (busy !== 1'b1) begin
            st  = -1;
            row = 0;
            for (int r = 1; r <= 64; r++) due[r] = -1;
        end else begin
            if (pe_query_load) begin
                st++;
                row = 0;
            end
            if (pe_ref_valid && row < 64) begin
                row++;
                due[row] = cyc + 2 + ((late && row == 64) ? 20 : 0);
                if (row == 10 && st < 2) begin
                    pe_best_valid = 1;
                    pe_best_score = 12;
                    pe_best_row   = (st == 0) ? 7'd5 : 7'd9;
                    pe_best_col   = (st == 0) ? 6'd3 : 6'd1;
                end
                if (row == 20 && st == 2 && third) begin
                    pe_best_valid = 1;
                    pe_best_score = 20;
                    pe_best_row   = 7'd64;
                    pe_best_col   = 6'd16;
                end
            end
            for (int r = 1; r <= 64; r++) if (due[r] == cyc) begin
                pe_last_valid = 1;
                pe_last_h     = 7'(r);
                pe_last_i     = 7'(-r);
                due[r]        = -1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int cnt, input int off, input logic [1:0] q);
        for (int i = 0; i < cnt; i++) begin
            data_ref   = 2'(i + off);
            data_query = q;
            valid      = 1;
            @(negedge clk);
        end
        valid = 0;
    endtask

    task automatic wait_load(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pe_query_load !== 1'b1 && n < 200);
        chk(tag, pe_query_load, 1);
    endtask

    task automatic wait_fin(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (finish !== 1'b1 && n < 200);
        chk(tag, finish, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_status", {busy, finish, pe_query_load, pe_ref_valid}, 4'b0);
        chk("rst_max", {max, pos_ref, pos_query}, 0);
        chk("rst_pe", {pe_query, pe_col_mask, pe_ref, pe_bnd_h, pe_bnd_i}, 0);
        reset = 0;
        late  = 1;
        third = 1;
        load(64, 0, 2'd3);
        chk("load_busy", busy, 1);
        wait_load("s0_load", n);
        chk("s0_load_lat", n, 1);
        chk("s0_query", {pe_query, pe_col_mask}, {32'hFFFF_FFFF, 16'hFFFF});
        chk("s0_query_lq40", {pe_query2, pe_col_mask2}, {32'hFFFF_FFFF, 16'hFFFF});
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            chk("s0_issue", {pe_ref_valid, pe_ref, pe_bnd_h, pe_bnd_i}, {1'b1, 2'(c), 7'd0, 7'(-30)});
            valid      = c >= 10 && c < 20;
            data_ref   = 2'(c + 1);
            data_query = 2'd0;
        end
        valid = 0;
        @(negedge clk);
        chk("s0_drain", {busy, pe_ref_valid, pe_query_load}, 3'b100);
        wait_load("s1_load", n);
        chk("drain_wait", n, 23);
        chk("s1_query", {pe_query, pe_col_mask}, {32'hFFFF_FFFF, 16'hFFFF});
        for (int r = 1; r <= 64; r++) begin
            @(negedge clk);
            chk("s1_issue", {pe_ref_valid, pe_ref, pe_bnd_h, pe_bnd_i}, {1'b1, 2'(r - 1), 7'(r), 7'(-r)});
        end
        chk("tie_hold", {max, pos_ref, pos_query}, {8'd12, 7'd5, 6'd3});
        wait_load("s2_load", n);
        chk("s2_lat", n, 24);
        chk("s2_query", {pe_query, pe_col_mask}, {32'hFFFF_FFFF, 16'hFFFF});
        chk("s2_pad", {pe_query2, pe_col_mask2}, {32'h0000_FFFF, 16'h00FF});
        for (int r = 1; r <= 64; r++) begin
            @(negedge clk);
            if (r == 1 || r == 64) chk("s2_bnd", {pe_bnd_h, pe_bnd_i}, {7'(r), 7'(-r)});
        end
        wait_fin("fin", n);
        chk("fin_lat", n, 24);
        @(negedge clk);
        chk("fin_pulse", {finish, busy}, 2'b00);
        chk("max_final", {max, pos_ref, pos_query}, {8'd20, 7'd64, 6'd48});
        chk("max_final_lq40", {max2, pos_ref2, pos_query2}, {8'd20, 7'd64, 6'd48});
        repeat (3) @(negedge clk);
        chk("max_hold", {max, pos_ref, pos_query}, {8'd20, 7'd64, 6'd48});

        late  = 0;
        third = 0;
        load(64, 0, 2'd1);
        chk("load_clr", {busy, max, pos_ref, pos_query}, {1'b1, 21'd0});
        wait_load("r2_s0", n);
        chk("r2_query", {pe_query, pe_col_mask}, {32'h5555_5555, 16'hFFFF});
        repeat (64) @(negedge clk);
        wait_load("r2_s1", n);
        chk("stripe_len", n, 4);
        repeat (64) @(negedge clk);
        chk("r2_max", {max, pos_ref, pos_query}, {8'd12, 7'd5, 6'd3});
        @(negedge clk);
        chk("r2_drain", {busy, pe_ref_valid}, 2'b10);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mid_rst", {busy, finish, pe_ref_valid, pe_query_load, max, pos_ref, pos_query}, 0);

        load(50, 1, 2'd2);
        wait_load("r3_s0", n);
        chk("r3_query", {pe_query, pe_col_mask}, {32'hAAAA_AAAA, 16'hFFFF});
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            chk("r3_short_ref", {pe_ref_valid, pe_ref}, {1'b1, c < 50 ? 2'(c + 1) : 2'd0});
        end
        wait_load("r3_s1", n);
        repeat (64) @(negedge clk);
        wait_load("r3_s2", n);
        chk("r3_pad", {pe_query2, pe_col_mask2}, {32'h0000_AAAA, 16'h00FF});
        repeat (64) @(negedge clk);
        wait_fin("r3_fin", n);
        chk("r3_fin_lat", n, 4);
        chk("r3_max", {max, pos_ref, pos_query}, {8'd12, 7'd5, 6'd3});
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sw_stripe_scheduler.md
Name: sw_stripe_scheduler

Overview:
- Sequencing controller for a PE_NUM-wide systolic Smith-Waterman PE array.
- Buffers the serially loaded reference and query.
- Splits the query into stripes of PE_NUM columns and streams the reference through the array once per stripe.
- Stores and replays the last-column H/I boundary between stripes, and reduces per-cycle best-cell reports into a global max and position with a finish pulse.

Parameters:
- LEN_REF, 64, reference length (symbols).
- LEN_QUERY, 48, query length (symbols).
- PE_NUM, 16, PE count = query columns per stripe.
- WIDTH_SCORE, 8, unsigned score width.
- WIDTH_POS_REF, 7, reference position width.
- WIDTH_POS_QUERY, 6, query position width.
- WIDTH_HI, 7, signed H/I boundary width.
- NEG_INIT, -30, I value injected on the first-stripe boundary.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- valid  in  1  load strobe; one symbol pair per cycle.
- data_ref  in  2  reference symbol.
- data_query  in  2  query symbol; used during the first LEN_QUERY load cycles.
- pe_query_load  out  1  one-cycle pulse; PEs latch pe_query.
- pe_query  out  2*PE_NUM  query symbols for the current stripe; PE k gets bits [2k+1:2k].
- pe_col_mask  out  PE_NUM  1 = column exists; 0 = padding beyond LEN_QUERY.
- pe_ref_valid  out  1  pe_ref/pe_bnd_* valid this cycle.
- pe_ref  out  2  reference symbol into PE0.
- pe_bnd_h  out  WIDTH_HI  left-boundary H for the current row.
- pe_bnd_i  out  WIDTH_HI  left-boundary I for the current row.
- pe_last_valid  in  1  last PE produced a row result.
- pe_last_h  in  WIDTH_HI  last-PE H.
- pe_last_i  in  WIDTH_HI  last-PE I.
- pe_best_valid  in  1  best report valid.
- pe_best_score  in  WIDTH_SCORE  best H reported this cycle.
- pe_best_row  in  WIDTH_POS_REF  1-based reference row of that H.
- pe_best_col  in  WIDTH_POS_QUERY  1-based column within the stripe.
- busy  out  1  high outside IDLE.
- finish  out  1  one-cycle done pulse.
- max  out  WIDTH_SCORE  best score.
- pos_ref  out  WIDTH_POS_REF  reference position of max.
- pos_query  out  WIDTH_POS_QUERY  query position of max.

Behaviour:
- Reset (synchronous) from any state, including mid-stripe:
  - state returns to IDLE;
  - all outputs 0;
  - R/Q/boundary memories don't-care.
- States are IDLE, LOAD, SETUP, ISSUE, DRAIN, DONE.
- IDLE:
  - valid=1 moves to LOAD.
  - R/Q are cleared to 0, max/pos are cleared, and the symbol on that same cycle is stored as R[1]/Q[1].
- LOAD:
  - Each valid cycle stores data_ref at R[n] for n<=LEN_REF, and data_query at Q[n] for n<=LEN_QUERY.
  - Symbols beyond those lengths are discarded.
  - valid=0 moves to SETUP with stripe s=0. A short load leaves the unfilled entries 0.
- SETUP (1 cycle):
  - pe_query_load=1.
  - pe_query = Q[s*PE_NUM+1 .. s*PE_NUM+PE_NUM]; padded entries are 0 with mask bit 0.
  - Moves to ISSUE with c=0.
- ISSUE (exactly LEN_REF cycles):
  - pe_ref_valid=1 and pe_ref=R[c+1].
  - Boundary: s=0 gives pe_bnd_h=0 and pe_bnd_i=NEG_INIT; otherwise bnd_h[c+1] and bnd_i[c+1].
  - After c=LEN_REF-1, moves to DRAIN.
- Boundary capture (in ISSUE and DRAIN):
  - Each pe_last_valid writes pe_last_h/i at write pointer wp, then increments wp. wp resets to 1 in SETUP.
  - Reads in stripe s+1 follow completion of all writes of stripe s, so there is no read/write hazard.
  - A single buffer is sufficient.
- DRAIN:
  - pe_ref_valid=0.
  - Waits until wp=LEN_REF+1, i.e. all LEN_REF rows returned.
  - Then: if s+1 < ceil(LEN_QUERY/PE_NUM), increments s and goes to SETUP; else goes to DONE.
  - The pe_best_valid in the same cycle as the final pe_last_valid is still accepted.
- Max reduction (in ISSUE and DRAIN, on pe_best_valid):
  - Update only if pe_best_score > max (strict).
  - On update: pos_ref=pe_best_row, pos_query=s*PE_NUM+pe_best_col.
  - Ties keep the earlier report.
  - If max stays 0, pos stays 0.
- DONE (1 cycle): finish=1, then goes to IDLE. max/pos hold until the next IDLE->LOAD transition.
- valid is ignored in SETUP, ISSUE, DRAIN and DONE.
- pe_last_valid/pe_best_valid are ignored outside ISSUE/DRAIN.
- busy=0 only in IDLE.
- Arithmetic: the boundary is stored raw (signed WIDTH_HI); max uses an unsigned compare at WIDTH_SCORE.
- Cycle count with a PE model whose last row returns D cycles after the final issue:
  - each stripe = 1 + LEN_REF + D + 1;
  - total = load + stripes*(LEN_REF+D+2) + 1.

Test Plan:
- Reset and load:
  - Stimulus: reset, then 64 valid cycles with ref=0..3 repeating and query=3 constant.
  - Required: R[1]=0, R[64]=3; first SETUP pe_query = all 3s with mask 0xFFFF; ISSUE pe_ref sequence 0,1,2,3...
- Stripe boundary replay:
  - Stimulus: PE model returns pe_last_h=row, pe_last_i=-row in stripe 0.
  - Required: stripe 1 drives pe_bnd_h=1..64 and pe_bnd_i=-1..-64; stripe 0 drives 0/-30.
- Padding:
  - Stimulus: LEN_QUERY=40, PE_NUM=16.
  - Required: 3 stripes; the third has mask 0x00FF and pe_query upper 16 bits 0.
- Max and ties:
  - Stimulus: best reports (score 12, row 5, col 3) in s=0, then (12, 9, 1) in s=1, then (20, 64, 16) in s=2.
  - Required: max=20, pos_ref=64, pos_query=48; without the third report, pos=(5,3).
- Drain wait:
  - Stimulus: PE model delays the final pe_last_valid 20 cycles.
  - Required: stays in DRAIN, no pe_query_load until the 64th result; finish occurs exactly one cycle after the last stripe's drain completes.
- Mid-run reset and ignore:
  - Stimulus: valid=1 during ISSUE.
  - Required: no effect.
  - Stimulus: reset asserted in stripe 1 DRAIN.
  - Required: next cycle busy=0, finish=0, max=0, and a new load then runs cleanly.
